// File: rtl/expr_vector_sequencer.sv
// Drives LFSR-generated operand vectors into a combinational expression block,
// folds each result into a 32-bit MISR and compares the final signature.
module expr_vector_sequencer #(
  parameter int SETTLE_MAX = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] vec_count,
  input  logic [63:0] seed,
  input  logic [1:0]  settle,
  input  logic [31:0] golden_sig,
  input  logic [89:0] y_in,
  output logic [59:0] op_bus,
  output logic        busy,
  output logic        done,
  output logic [31:0] signature,
  output logic        sig_valid,
  output logic        pass,
  output logic [15:0] vec_idx
);

  typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, CAPTURE, DONE} state_t;

  localparam logic [1:0] SMAX = SETTLE_MAX[1:0];

  state_t      state, state_nx;
  logic [63:0] lfsr, lfsr_nx;
  logic [31:0] misr, misr_nx, y_fold;
  logic [15:0] cnt_q, idx, idx_inc;
  logic [1:0]  settle_q, settle_in, scnt;
  logic        sv;

  assign settle_in = (settle > SMAX) ? SMAX : settle;
  assign y_fold    = y_in[31:0] ^ y_in[63:32] ^ {6'b0, y_in[89:64]};
  assign misr_nx   = {misr[30:0], misr[31] ^ misr[21] ^ misr[1] ^ misr[0]} ^ y_fold;
  assign lfsr_nx   = {lfsr[62:0], lfsr[63] ^ lfsr[62] ^ lfsr[60] ^ lfsr[59]};
  assign idx_inc   = idx + 16'd1;

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    op_bus   = '0;
    unique case (state)
      IDLE:    if (start) state_nx = (vec_count == 16'd0) ? DONE : DRIVE;
      DRIVE: begin
        busy     = 1'b1;
        op_bus   = lfsr[59:0];
        state_nx = abort ? IDLE : ((settle_q != 2'd0) ? SETTLE : CAPTURE);
      end
      SETTLE: begin
        busy   = 1'b1;
        op_bus = lfsr[59:0];
        if (abort)              state_nx = IDLE;
        else if (scnt == 2'd0)  state_nx = CAPTURE;
      end
      CAPTURE: begin
        busy     = 1'b1;
        op_bus   = lfsr[59:0];
        state_nx = abort ? IDLE : ((idx_inc == cnt_q) ? DONE : DRIVE);
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // The LFSR only moves at the end of CAPTURE, so op_bus stays put for the
  // whole DRIVE/SETTLE/CAPTURE window of a vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      lfsr     <= 64'h1;
      misr     <= 32'hFFFF_FFFF;
      cnt_q    <= '0;
      idx      <= '0;
      settle_q <= '0;
      scnt     <= '0;
      sv       <= 1'b0;
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: if (start) begin
          cnt_q    <= vec_count;
          settle_q <= settle_in;
          lfsr     <= (seed == 64'd0) ? 64'h1 : seed;
          misr     <= 32'hFFFF_FFFF;
          idx      <= '0;
          sv       <= 1'b0;
        end
        DRIVE:   scnt <= settle_q - 2'd1;
        SETTLE:  scnt <= scnt - 2'd1;
        CAPTURE: if (!abort) begin
          misr <= misr_nx;
          lfsr <= lfsr_nx;
          idx  <= idx_inc;
        end
        DONE:    sv <= 1'b1;
        default: ;
      endcase
      if (abort && busy) sv <= 1'b0;
    end
  end

  assign signature = misr;
  assign sig_valid = sv;
  assign pass      = sv && (misr == golden_sig);
  assign vec_idx   = idx;

endmodule

// File: tb/tb_expr_vector_sequencer.sv
// Randomized bench for expr_vector_sequencer against a cycle-timing and
// signature reference model computed from the sequencing rules.
module tb_expr_vector_sequencer;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
  logic [15:0] vec_count = '0;
  logic [63:0] seed = '0;
  logic [1:0]  settle = '0;
  logic [31:0] golden_sig = '0;
  logic [89:0] y_in;
  logic [59:0] op_bus;
  logic        busy, done, sig_valid, pass;
  logic [31:0] signature;
  logic [15:0] vec_idx;

  int          ymode = 0;
  int          n_chk = 0, n_bad = 0;
  logic [59:0] exp_ops[$];
  logic [31:0] exp_sig;

  always #5 clk = ~clk;

  expr_vector_sequencer #(.SETTLE_MAX(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .vec_count(vec_count), .seed(seed), .settle(settle),
    .golden_sig(golden_sig), .y_in(y_in), .op_bus(op_bus), .busy(busy),
    .done(done), .signature(signature), .sig_valid(sig_valid), .pass(pass),
    .vec_idx(vec_idx)
  );

  // Stand-in for the expression block under test
  function automatic logic [89:0] yexpr(logic [59:0] op, int mode);
    if (mode == 1) return '0;
    if (mode == 2) return 90'h1 << 64;
    return {op[29:0], op ^ {op[29:0], op[59:30]}};
  endfunction

  always_comb y_in = yexpr(op_bus, ymode);

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic model(int n, logic [63:0] sd);
    logic [63:0] l;
    logic [31:0] m, f;
    logic [89:0] y;
    l = (sd == 64'd0) ? 64'h1 : sd;
    m = 32'hFFFF_FFFF;
    exp_ops.delete();
    for (int i = 0; i < n; i++) begin
      exp_ops.push_back(l[59:0]);
      y = yexpr(l[59:0], ymode);
      f = y[31:0] ^ y[63:32] ^ {6'b0, y[89:64]};
      m = {m[30:0], ^(m & 32'h8020_0003)} ^ f;
      l = {l[62:0], ^(l & 64'hD800_0000_0000_0000)};
    end
    exp_sig = m;
  endtask

  task automatic chk_reset_vals(string tag);
    chk({tag, "_op"}, op_bus, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_sig"}, signature, 32'hFFFF_FFFF);
    chk({tag, "_sv"}, sig_valid, 0);
    chk({tag, "_pass"}, pass, 0);
    chk({tag, "_idx"}, vec_idx, 0);
  endtask

  // abort_k / rst_k: cycle after the start edge at which to abort / reset (0 = never)
  task automatic run(int n, logic [63:0] sd, logic [1:0] s, bit match, int abort_k, int rst_k);
    int per, last;
    logic [31:0] gold;
    per  = 2 + int'(s);
    last = n * per + 1;
    model(n, sd);
    gold = match ? exp_sig : ~exp_sig;
    @(negedge clk);
    vec_count = 16'(n); seed = sd; settle = s; golden_sig = gold;
    start = 1'b1; abort = 1'($urandom_range(0, 1));
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    for (int k = 1; k <= last; k++) begin
      chk("done", done, k == last);
      chk("busy", busy, k < last);
      chk("sig_valid_run", sig_valid, 0);
      if (k < last) begin
        chk("op_bus", op_bus, exp_ops[(k-1)/per]);
        chk("vec_idx", vec_idx, (k-1)/per);
      end else begin
        chk("op_bus_done", op_bus, 0);
      end
      if (k == abort_k) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0; start = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_op", op_bus, 0);
        chk("abort_sv", sig_valid, 0);
        for (int j = 0; j < last + 2; j++) begin
          chk("abort_nodone", done, 0);
          @(negedge clk);
        end
        return;
      end
      if (k == rst_k) begin
        rst_n = 1'b0;
        #1;
        chk_reset_vals("async_rst");
        @(negedge clk);
        rst_n = 1'b1; start = 1'b0;
        return;
      end
      // Junk on the run inputs must not disturb an active run
      start = 1'($urandom_range(0, 1));
      vec_count = 16'($urandom);
      seed = {$urandom, $urandom};
      settle = 2'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    chk("sig_valid_end", sig_valid, 1);
    chk("signature", signature, exp_sig);
    chk("pass", pass, match);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;

    ymode = 0;
    run(0, 64'h5, 2'd0, 1'b1, 0, 0);
    chk("n0_sig", signature, 32'hFFFF_FFFF);
    chk("n0_pass", pass, 1);

    ymode = 1;
    run(1, 64'h1, 2'd0, 1'b1, 0, 0);
    chk("y0_sig", signature, 32'hFFFF_FFFE);

    ymode = 2;
    run(1, 64'h1, 2'd0, 1'b1, 0, 0);
    chk("y64_sig_seed1", signature, 32'hFFFF_FFFF);
    run(1, 64'h0, 2'd0, 1'b1, 0, 0);
    chk("y64_sig_seed0", signature, 32'hFFFF_FFFF);

    ymode = 0;
    run(3, {$urandom, $urandom}, 2'd3, 1'b1, 0, 0);
    run(3, {$urandom, $urandom}, 2'd2, 1'b1, 6, 0);
    run(2, {$urandom, $urandom}, 2'd1, 1'b0, 0, 0);
    run(3, {$urandom, $urandom}, 2'd1, 1'b1, 0, 6);
    run(2, {$urandom, $urandom}, 2'd0, 1'b1, 0, 0);

    for (int r = 0; r < 12; r++) begin
      logic [63:0] sd;
      sd = ($urandom_range(0, 3) == 0) ? 64'd0 : {$urandom, $urandom};
      run($urandom_range(1, 10), sd, 2'($urandom_range(0, 3)),
          1'($urandom_range(0, 1)), 0, 0);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
